// File: rtl/fma_norm_shift.sv
// fma_norm_shift: multi-cycle normalization left shifter between the FMA sum
// datapath and the rounding stage. Shifts by at most STEP bit positions per
// cycle. Results are handed over through a valid/ready handshake.

module fma_norm_shift #(
  parameter int NE     = 8,
  parameter int NF     = 23,
  parameter int FMALEN = 3*NF+6,
  parameter int STEP   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Flush,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [FMALEN-1:0]            Sm,
  input  logic [NE+1:0]                Se,
  input  logic                         Ss,
  input  logic                         ASticky,
  input  logic [$clog2(FMALEN+1)-1:0]  SCnt,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [FMALEN-1:0]            Mf,
  output logic [NE+1:0]                Me,
  output logic                         Ms,
  output logic                         Sticky,
  output logic                         SumZero
);

  localparam int CW = $clog2(FMALEN+1);
  localparam logic [CW-1:0] LEN_C  = CW'(FMALEN);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counts larger than the significand width shift everything out anyway.
  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] cnt);
    return (cnt > LEN_C) ? LEN_C : cnt;
  endfunction

  // Distance covered in one shift cycle.
  function automatic logic [CW-1:0] step_of(input logic [CW-1:0] rem);
    return (rem > STEP_C) ? STEP_C : rem;
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [FMALEN-1:0]   mf_r;
  logic [NE+1:0]       me_r;
  logic                ms_r;
  logic                sticky_r;
  logic                sum_zero_r;
  logic [CW-1:0]       rem_r;

  logic                accept_s;
  logic                sum_zero_s;
  logic [CW-1:0]       cap_rem_s;
  logic [NE+1:0]       cap_me_s;
  logic [CW-1:0]       shift_k_s;
  logic [CW-1:0]       rem_next_s;
  logic [FMALEN-1:0]   mf_shift_s;

  // Operand capture values and the per-cycle shift step.
  always_comb begin
    accept_s   = InValid & in_ready_r;
    sum_zero_s = (Sm == {FMALEN{1'b0}});
    cap_rem_s  = clamp_cnt(SCnt);
    cap_me_s   = Se - (NE+2)'(cap_rem_s);
    shift_k_s  = step_of(rem_r);
    rem_next_s = rem_r - shift_k_s;
    mf_shift_s = mf_r << shift_k_s;
  end

  // Next-state decode; Flush overrides both capture and the output handshake.
  always_comb begin
    state_nx_s = state_r;
    if (Flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if ((cap_rem_s == {CW{1'b0}}) || sum_zero_s) begin
              state_nx_s = ST_DONE;
            end else begin
              state_nx_s = ST_SHIFT;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (rem_next_s == {CW{1'b0}}) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (OutReady) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Control state plus registered handshake flags that mirror the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
    end
  end

  // Datapath: load on accept, shift while in SHIFT, otherwise hold (incl. Flush).
  always_ff @(posedge clk) begin
    if (!reset) begin
      mf_r       <= {FMALEN{1'b0}};
      me_r       <= {(NE+2){1'b0}};
      ms_r       <= 1'b0;
      sticky_r   <= 1'b0;
      sum_zero_r <= 1'b0;
      rem_r      <= {CW{1'b0}};
    end else if (!Flush && (state_r == ST_IDLE) && accept_s) begin
      mf_r       <= Sm;
      me_r       <= cap_me_s;
      ms_r       <= Ss;
      sticky_r   <= ASticky;
      sum_zero_r <= sum_zero_s;
      rem_r      <= cap_rem_s;
    end else if (!Flush && (state_r == ST_SHIFT)) begin
      mf_r       <= mf_shift_s;
      rem_r      <= rem_next_s;
    end else begin
      mf_r       <= mf_r;
      rem_r      <= rem_r;
    end
  end

  assign InReady  = in_ready_r;
  assign OutValid = out_valid_r;
  assign Mf       = mf_r;
  assign Me       = me_r;
  assign Ms       = ms_r;
  assign Sticky   = sticky_r;
  assign SumZero  = sum_zero_r;

  fma_norm_shift_chk #(
    .FW (FMALEN),
    .EW (NE+2)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .Flush    (Flush),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Mf       (Mf),
    .Me       (Me),
    .Ms       (Ms),
    .Sticky   (Sticky),
    .SumZero  (SumZero)
  );

endmodule

// Protocol checker for fma_norm_shift: handshake exclusivity and result hold.
module fma_norm_shift_chk #(
  parameter int FW = 75,
  parameter int EW = 10
) (
  input logic          clk,
  input logic          reset,
  input logic          Flush,
  input logic          InReady,
  input logic          OutValid,
  input logic          OutReady,
  input logic [FW-1:0] Mf,
  input logic [EW-1:0] Me,
  input logic          Ms,
  input logic          Sticky,
  input logic          SumZero
);

  // The block is never ready for input and presenting a result at once.
  a_excl: assert property (@(posedge clk) disable iff (!reset)
    !(InReady && OutValid));

  // A stalled result stays valid and unchanged.
  a_hold: assert property (@(posedge clk) disable iff (!reset)
    (OutValid && !OutReady && !Flush) |=>
      (OutValid && $stable(Mf) && $stable(Me) && $stable(Ms) &&
       $stable(Sticky) && $stable(SumZero)));

endmodule

// File: doc/fma_norm_shift.md
# fma_norm_shift

Multi-cycle normalization shifter that sits directly downstream of the FMA significand/exponent datapath. It captures the positive sum significand `Sm`, sum exponent `Se`, sign `Ss`, alignment sticky `ASticky`, and normalization count `SCnt`. It then left-shifts `Sm` by `SCnt` in bounded steps per cycle, saving area relative to a full single-cycle barrel shifter. The normalized significand and adjusted exponent go to the rounding stage over a valid/ready handshake.

## Interface
- `NE`, default 8: exponent field width.
- `NF`, default 23: fraction width.
- `FMALEN`, default 3*NF+6 (75): sum significand width.
- `STEP`, default 16: maximum left-shift distance per cycle, 1 ≤ STEP ≤ FMALEN.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `Flush`, input, 1: synchronous abort of any in-flight operation.
- `InValid`, input, 1: upstream operands valid.
- `InReady`, output, 1: block can accept operands.
- `Sm`, input, FMALEN: positive sum significand.
- `Se`, input, NE+2: sum exponent, two's complement.
- `Ss`, input, 1: sum sign.
- `ASticky`, input, 1: alignment sticky bit.
- `SCnt`, input, $clog2(FMALEN+1): normalization shift count.
- `OutValid`, output, 1: result valid.
- `OutReady`, input, 1: downstream accepts result.
- `Mf`, output, FMALEN: normalized significand.
- `Me`, output, NE+2: normalized exponent.
- `Ms`, output, 1: result sign.
- `Sticky`, output, 1: registered `ASticky`.
- `SumZero`, output, 1: captured `Sm` was all zeros.

## Operation
- FSM states:
  - IDLE (`InReady`=1)
  - SHIFT
  - DONE (`OutValid`=1)
- `InReady` is 1 only in IDLE. `OutValid` is 1 only in DONE.
- IDLE, on `InValid`&`InReady`, capture the operands:
  - Mf←`Sm`.
  - Rem←min(`SCnt`, FMALEN).
  - Me←`Se` − zero-extended Rem, modulo 2^(NE+2) (wrap-around, no saturation).
  - Ms←`Ss`.
  - Sticky←`ASticky`.
  - SumZero←(`Sm`==0).
- Next state after capture:
  - DONE if Rem==0 or `Sm`==0.
  - Otherwise SHIFT.
- SHIFT, each cycle:
  - k=min(Rem, STEP).
  - Mf←Mf<<k, zero-filled; bits shifted past bit FMALEN-1 are discarded.
  - Rem←Rem−k.
  - Go to DONE when the new Rem is 0.
- DONE:
  - Outputs are held stable while `OutReady`=0.
  - On `OutReady`=1, go to IDLE.
  - No new input is accepted in the same cycle.
- SumZero case: Mf=0 and Me=`Se`−Rem. The shift is skipped, but the exponent is still adjusted.
- Clamp: if `SCnt` > FMALEN, it is treated as FMALEN, so Mf ends at 0.
- `Flush`=1 in any state: next state is IDLE and `OutValid` drops the next cycle. Datapath registers keep their values. `Flush` has priority over capture and over the DONE handshake.
- `reset`=0 has priority over `Flush`:
  - State IDLE.
  - `Mf`, `Me`, `Ms`, `Sticky`, `SumZero`, and Rem all zero.
  - `InReady`=0 while `reset`=0, and 1 the first cycle after release.
  - `OutValid`=0.
- Reset mid-SHIFT or mid-DONE discards the operation. No output is produced.

## Timing
- Capture cycle, then ceil(min(`SCnt`,FMALEN)/STEP) SHIFT cycles. `OutValid` rises on the edge that ends the last SHIFT cycle.
- Latency, accept edge to `OutValid`=1:
  - 1 cycle when Rem==0 or `Sm`==0.
  - Otherwise 1+ceil(Rem/STEP) cycles.
- Minimum initiation interval: 2 cycles (accept, DONE with `OutReady`=1, IDLE).
- All outputs are registered. There is no combinational path from `InValid` or `OutReady` to any output. `InReady` and `OutValid` are pure decodes of the state.
- Output fields change only on the capture edge and on SHIFT edges, never while `OutValid`=1.

## Test plan
- Basic multi-step shift (defaults):
  - Stimulus: `Sm`=1<<40, `SCnt`=34, `Se`=10'd130, `OutReady`=1.
  - Required: `OutValid` 4 cycles after accept; `Mf`=1<<74; `Me`=96.
  - Check 3 SHIFT cycles (16, 16, 2).
- Zero count: `SCnt`=0, `Sm`=1<<74 → `OutValid` 1 cycle after accept; `Mf` unchanged; `Me`=`Se`.
- Zero sum and exponent wrap:
  - Stimulus: `Sm`=0, `SCnt`=5, `Se`=3.
  - Required: 1-cycle latency; `SumZero`=1; `Mf`=0; `Me`=10'h3FE (wrapped −2).
- Clamp:
  - Stimulus: `SCnt`=127, `Sm`=75'h7FF, `Se`=200.
  - Required: Rem clamped to 75; 5 SHIFT cycles; `Mf`=0; `Me`=125.
- Backpressure:
  - Stimulus: hold `OutReady`=0 for 5 cycles in DONE while driving `InValid`=1.
  - Required: outputs stable; `InReady`=0.
  - Then `OutReady`=1: IDLE next cycle, and the pending input is accepted the cycle after.
- Abort paths:
  - `Flush` asserted in the 2nd SHIFT cycle → IDLE, `OutValid` never rises.
  - `reset`=0 during DONE → `OutValid`=0 and all outputs 0 next cycle; `InReady`=1 the cycle after `reset` returns to 1.
